// File: rtl/pe_feeder_pkg.sv
// Shared types and constants for the PE weight/iact feeder.
package pe_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Memory read latency and total strobe-to-output latency.
    localparam int MEM_LAT = 1;
    localparam int OUT_LAT = 2;

    // Side-band flags that travel with each iact.
    typedef struct packed {
        logic bank;
        logic last;
    } iact_tag_t;

endpackage

// File: rtl/pe_feeder_if.sv
// Memory and PE-side bus of the feeder; master is the feeder itself.
interface pe_feeder_if #(
    parameter int N   = 16,
    parameter int AW  = 8,
    parameter int MAW = 16
);
    logic           start;
    logic [AW:0]    fan_in;
    logic [7:0]     num_neurons;
    logic           wmem_rd;
    logic [MAW-1:0] wmem_addr;
    logic [N-1:0]   wmem_data;
    logic           amem_rd;
    logic [AW-1:0]  amem_addr;
    logic [N-1:0]   amem_data;
    logic           pe_ready;
    logic [N-1:0]   weight;
    logic           weight_valid;
    logic           weight_bank;
    logic [N-1:0]   iact;
    logic           iact_valid;
    logic           read_bank;
    logic           neuron_last;
    logic           busy;
    logic           done;

    modport master (
        input  start, fan_in, num_neurons, wmem_data, amem_data, pe_ready,
        output wmem_rd, wmem_addr, amem_rd, amem_addr, weight, weight_valid,
               weight_bank, iact, iact_valid, read_bank, neuron_last, busy, done
    );

    modport slave (
        output start, fan_in, num_neurons, wmem_data, amem_data, pe_ready,
        input  wmem_rd, wmem_addr, amem_rd, amem_addr, weight, weight_valid,
               weight_bank, iact, iact_valid, read_bank, neuron_last, busy, done
    );
endinterface

// File: rtl/pe_feeder_feed_pipe.sv
// Two-stage valid/tag/data delay line: strobe and tag enter at stage 0,
// memory data is picked up one cycle later, everything leaves registered.
module feed_pipe
    import pe_feeder_pkg::*;
#(
    parameter int W  = 16,
    parameter int TW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [TW-1:0] in_tag,
    input  logic [W-1:0]  mem_data,
    output logic          out_vld,
    output logic [TW-1:0] out_tag,
    output logic [W-1:0]  out_data
);
    logic [OUT_LAT:1]         vld_pipe;
    logic [OUT_LAT:1][TW-1:0] tag_pipe;
    logic [W-1:0]             data_q;

    // Shift valid and tag; capture memory data as it lands, zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            data_q   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[OUT_LAT-1:1], in_vld};
            tag_pipe <= {tag_pipe[OUT_LAT-1:1], in_tag};
            data_q   <= vld_pipe[MEM_LAT] ? mem_data : '0;
        end
    end

    assign out_vld  = vld_pipe[OUT_LAT];
    assign out_tag  = tag_pipe[OUT_LAT];
    assign out_data = data_q;
endmodule

// File: rtl/pe_feeder.sv
// Streams one MLP layer into a PE: weights into ping-pong banks, iacts per
// neuron, with the next neuron's weights loading under the current iacts.
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int N   = 16,
    parameter int AW  = 8,
    parameter int MAW = 16
) (
    input logic         clk,
    input logic         rst,
    pe_feeder_if.master bus
);
    state_t         state, state_nx;
    logic [AW:0]    fan_q, fan_m1, wi, ai;
    logic [7:0]     nn_q, ncnt;
    logic [MAW-1:0] base;
    logic           wact, rbank, wbank, dcnt;
    logic           w_issue, w_last, w_fin, a_issue, a_last, a_fin;
    logic           last_n, bound, nxt_load;
    iact_tag_t      a_tag, o_tag;

    assign fan_m1  = fan_q - (AW+1)'(1);
    assign w_issue = (state == FILL) || (state == RUN && wact);
    assign w_last  = (wi == fan_m1);
    // A load counts as finished while its last word issues, except a
    // one-word load, which must be seen complete first: one bubble per
    // neuron at fan_in=1, none otherwise.
    assign w_fin   = !wact || (w_issue && w_last && wi != '0);
    assign a_issue = (state == RUN) && (ai != fan_q) && bus.pe_ready;
    assign a_last  = (ai == fan_m1);
    assign a_fin   = (ai == fan_q) || (a_issue && a_last);
    assign last_n  = (ncnt == nn_q - 8'd1);
    assign bound   = (state == RUN) && a_fin && w_fin && !last_n;
    // After the flip, neuron ncnt+2 needs loading if it exists.
    assign nxt_load = ({1'b0, ncnt} + 9'd2) < {1'b0, nn_q};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = FILL;
            FILL:    if (w_last) state_nx = RUN;
            RUN:     if (a_issue && a_last && last_n) state_nx = DRAIN;
            DRAIN:   if (dcnt) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counters, address base and bank pointers for both engines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fan_q <= '0; nn_q <= '0; base <= '0; wi <= '0; ai <= '0;
            ncnt  <= '0; wact <= 1'b0; rbank <= 1'b0; wbank <= 1'b0; dcnt <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                fan_q <= bus.fan_in; nn_q <= bus.num_neurons;
                base  <= '0; wi <= '0; ai <= '0; ncnt <= '0;
                wact  <= 1'b0; rbank <= 1'b0; wbank <= 1'b0;
            end
            if (w_issue) begin
                if (w_last) begin
                    wi   <= '0;
                    base <= base + MAW'(fan_q);
                    wact <= 1'b0;
                end else begin
                    wi <= wi + (AW+1)'(1);
                end
            end
            if (state == FILL && w_last) begin
                rbank <= 1'b0;
                wbank <= 1'b1;
                wact  <= (nn_q > 8'd1);
            end
            if (a_issue) ai <= ai + (AW+1)'(1);
            if (bound) begin
                rbank <= ~rbank;
                wbank <= ~wbank;
                ncnt  <= ncnt + 8'd1;
                ai    <= '0;
                wi    <= '0;
                wact  <= nxt_load;
            end
            dcnt <= (state == DRAIN) ? ~dcnt : 1'b0;
        end
    end

    // Strobes, addresses and status decoded from state.
    always_comb begin
        bus.wmem_rd   = w_issue;
        bus.wmem_addr = w_issue ? base + MAW'(wi) : '0;
        bus.amem_rd   = a_issue;
        bus.amem_addr = a_issue ? ai[AW-1:0] : '0;
        bus.busy      = (state != IDLE);
        bus.done      = (state == DRAIN) && dcnt;
    end

    assign a_tag = '{bank: a_issue & rbank, last: a_issue & a_last};

    feed_pipe #(.W(N), .TW(1)) u_wpipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (w_issue),
        .in_tag   (w_issue & wbank),
        .mem_data (bus.wmem_data),
        .out_vld  (bus.weight_valid),
        .out_tag  (bus.weight_bank),
        .out_data (bus.weight)
    );

    feed_pipe #(.W(N), .TW($bits(iact_tag_t))) u_apipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (a_issue),
        .in_tag   (a_tag),
        .mem_data (bus.amem_data),
        .out_vld  (bus.iact_valid),
        .out_tag  (o_tag),
        .out_data (bus.iact)
    );

    assign bus.read_bank   = o_tag.bank;
    assign bus.neuron_last = o_tag.last;
endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: memories return addr-tagged words so each
// weight/iact seen at the PE side can be traced back to its address.
module tb_pe_feeder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_run = 0, n_fail = 0, cyc = 0;
    int done_cnt = 0, a_iss_cyc = 0, stall_iact = 0, conflict = 0;
    int w_addr[$], w_bank[$], w_cyc[$], i_idx[$], i_bank[$], i_last[$], i_cyc[$];

    pe_feeder_if #(.N(16), .AW(8), .MAW(16)) bus();
    pe_feeder #(.N(16), .AW(8), .MAW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Memories: one-cycle read latency, data encodes the address.
    always @(posedge clk) begin
        bus.wmem_data <= bus.wmem_rd ? 16'hA000 + bus.wmem_addr : 16'h0;
        bus.amem_data <= bus.amem_rd ? 16'h5000 + {8'h0, bus.amem_addr} : 16'h0;
    end

    // PE-side monitor.
    always @(negedge clk) begin
        cyc++;
        if (bus.weight_valid) begin
            w_addr.push_back(int'(bus.weight) - 32'hA000);
            w_bank.push_back(int'(bus.weight_bank));
            w_cyc.push_back(cyc);
        end
        if (bus.iact_valid) begin
            i_idx.push_back(int'(bus.iact) - 32'h5000);
            i_bank.push_back(int'(bus.read_bank));
            i_last.push_back(int'(bus.neuron_last));
            i_cyc.push_back(cyc);
            if (!bus.pe_ready) stall_iact++;
        end
        if (bus.weight_valid && bus.iact_valid && bus.weight_bank == bus.read_bank) conflict++;
        if (bus.amem_rd) a_iss_cyc = cyc;
        if (bus.done) done_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr();
        w_addr.delete(); w_bank.delete(); w_cyc.delete();
        i_idx.delete(); i_bank.delete(); i_last.delete(); i_cyc.delete();
        done_cnt = 0; stall_iact = 0;
    endtask

    task automatic go(input int fan, input int nn);
        clr();
        bus.fan_in = 9'(fan); bus.num_neurons = 8'(nn); bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin tick(1); n++; end
        tick(3);
        chk({tag, "_done_once"}, done_cnt, 1);
    endtask

    function automatic int out_bits();
        return int'({bus.wmem_rd, bus.amem_rd, bus.weight_valid, bus.iact_valid,
                     bus.neuron_last, bus.read_bank, bus.weight_bank, bus.busy, bus.done})
             | int'(bus.weight) | int'(bus.iact) | int'(bus.wmem_addr) | int'(bus.amem_addr);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.fan_in = '0; bus.num_neurons = '0; bus.pe_ready = 1'b1;
        tick(3);
        chk("reset_outputs", out_bits(), 0);
        rst = 1'b1;
        tick(2);
        chk("idle_outputs", out_bits(), 0);

        // T1: fan_in=4, one neuron.
        go(4, 1);
        wait_done("t1", 100);
        chk("t1_nw", w_addr.size(), 4);
        chk("t1_ni", i_idx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_waddr%0d", i), w_addr[i], i);
            chk($sformatf("t1_wbank%0d", i), w_bank[i], 0);
            chk($sformatf("t1_idx%0d", i), i_idx[i], i);
            chk($sformatf("t1_rbank%0d", i), i_bank[i], 0);
            chk($sformatf("t1_last%0d", i), i_last[i], (i == 3) ? 1 : 0);
        end
        chk("t1_done_lat", i_cyc[3] - a_iss_cyc, 2);
        chk("t1_busy_off", int'(bus.busy), 0);

        // T2: fan_in=4, three neurons; a stray start while busy is ignored.
        go(4, 3);
        tick(2);
        bus.fan_in = 9'd2; bus.num_neurons = 8'd1; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        wait_done("t2", 200);
        chk("t2_nw", w_addr.size(), 12);
        chk("t2_ni", i_idx.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t2_waddr%0d", i), w_addr[i], i);
            chk($sformatf("t2_wbank%0d", i), w_bank[i], (i / 4) % 2);
            chk($sformatf("t2_idx%0d", i), i_idx[i], i % 4);
            chk($sformatf("t2_rbank%0d", i), i_bank[i], (i / 4) % 2);
            chk($sformatf("t2_last%0d", i), i_last[i], (i % 4 == 3) ? 1 : 0);
        end
        chk("t2_no_gap", i_cyc[11] - i_cyc[0], 11);
        chk("t2_overlap", int'(w_cyc[4] < i_cyc[3]), 1);

        // T3: pe_ready low for 3 cycles just after neuron 0 starts.
        go(4, 2);
        tick(5);
        bus.pe_ready = 1'b0;
        tick(3);
        bus.pe_ready = 1'b1;
        wait_done("t3", 200);
        chk("t3_stall_iacts", stall_iact, 1);
        chk("t3_ni", i_idx.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_idx%0d", i), i_idx[i], i % 4);
            chk($sformatf("t3_rbank%0d", i), i_bank[i], i / 4);
            chk($sformatf("t3_waddr%0d", i), w_addr[i], i);
        end
        chk("t3_resume_gap", i_cyc[1] - i_cyc[0], 4);
        chk("t3_wload_contig", w_cyc[7] - w_cyc[4], 3);

        // T4: fan_in=1, four neurons: one bubble per neuron, banks alternate.
        go(1, 4);
        wait_done("t4", 100);
        chk("t4_ni", i_idx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_idx%0d", i), i_idx[i], 0);
            chk($sformatf("t4_last%0d", i), i_last[i], 1);
            chk($sformatf("t4_rbank%0d", i), i_bank[i], i % 2);
            chk($sformatf("t4_waddr%0d", i), w_addr[i], i);
            chk($sformatf("t4_wbank%0d", i), w_bank[i], i % 2);
        end
        chk("t4_bubble", i_cyc[1] - i_cyc[0], 2);

        // T5: fan_in=256, two neurons: full index range, base 256 for neuron 1.
        go(256, 2);
        wait_done("t5", 2000);
        chk("t5_ni", i_idx.size(), 512);
        chk("t5_nw", w_addr.size(), 512);
        begin
            int bad = 0;
            for (int i = 0; i < 512 && i < i_idx.size() && i < w_addr.size(); i++) begin
                if (i_idx[i] != i % 256 || i_bank[i] != i / 256 || w_addr[i] != i) bad++;
            end
            chk("t5_seq_errors", bad, 0);
        end
        chk("t5_idx255", i_idx[255], 255);
        chk("t5_idx256", i_idx[256], 0);
        chk("t5_base_n1", w_addr[256], 256);
        chk("t5_last_n0", i_last[255], 1);
        chk("t5_no_gap", i_cyc[511] - i_cyc[0], 511);

        // T6: asynchronous reset in RUN, then a clean restart.
        go(4, 3);
        tick(6);
        chk("t6_pre_ivld", int'(bus.iact_valid), 1);
        chk("t6_pre_wvld", int'(bus.weight_valid), 1);
        #2 rst = 1'b0;
        #1 chk("t6_async_clear", out_bits(), 0);
        tick(3);
        chk("t6_no_done", done_cnt, 0);
        rst = 1'b1;
        tick(2);
        go(2, 1);
        wait_done("t6", 100);
        chk("t6_nw", w_addr.size(), 2);
        chk("t6_waddr0", w_addr[0], 0);
        chk("t6_waddr1", w_addr[1], 1);
        chk("t6_idx0", i_idx[0], 0);
        chk("t6_idx1", i_idx[1], 1);
        chk("t6_last1", i_last[1], 1);

        chk("bank_conflict", conflict, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_feeder.md
Name: pe_feeder

Overview:
Streams one MLP layer's weights and input activations into a PE.
- Weights go from a layer weight memory into the PE's two ping-pong weight banks.
- Activations go from an activation memory as one stream per neuron.
- While neuron n's activations stream out of bank b, neuron n+1's weights load into the other bank (~b), so each neuron costs about fan_in cycles.
- Sits between the layer memories and the PE weight/iact inputs, driving the bank select the PE demuxes on.

Parameters:
N, 16, data width of weights and activations
AW, 8, bank address width; bank depth = 2**AW
MAW, 16, weight-memory address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active low
start  in  1  one-cycle pulse; sampled only in IDLE
fan_in  in  AW+1  inputs per neuron, legal 1..2**AW; latched on start
num_neurons  in  8  neurons in layer, legal 1..255; latched on start
wmem_rd  out  1  weight memory read strobe
wmem_addr  out  MAW  weight memory address
wmem_data  in  N  read data, valid 1 cycle after wmem_rd
amem_rd  out  1  activation memory read strobe
amem_addr  out  AW  activation index
amem_data  in  N  read data, valid 1 cycle after amem_rd
pe_ready  in  1  PE may accept iacts; low = stall iact issue
weight  out  N  weight word to PE
weight_valid  out  1  weight is a write into bank weight_bank
weight_bank  out  1  target bank for weight (PE demux select)
iact  out  N  activation to PE
iact_valid  out  1  iact valid this cycle
read_bank  out  1  bank the PE must read for the current iact (PE mux select)
neuron_last  out  1  high with the final iact of each neuron
busy  out  1  high from start accepted until done
done  out  1  one-cycle pulse after the last iact of the last neuron

Behaviour:
- Reset (rst=0, async): state IDLE; all counters 0; every output 0.
- Read-to-output latency:
  - Strobe issued in cycle t; memory data arrives in t+1; registered weight/iact outputs appear in t+2.
  - Bank and last flags travel in the same 2-stage pipe as the data.
- Weight address: running base register plus index, wmem_addr = base + i; base += fan_in per neuron. No multiplier.
- States:
  - IDLE: start -> latch fan_in and num_neurons; base=0; wbank=0 -> FILL.
  - FILL: issue fan_in weight reads for neuron 0 into bank 0. After the last issue: -> RUN, rbank=0, wbank=1, load neuron 1 if num_neurons>1.
  - RUN: two engines run concurrently.
    - Iact engine: issues amem reads 0..fan_in-1 only in cycles with pe_ready=1. amem_rd = pe_ready while the iact count is not exhausted.
    - Weight engine: loads the next neuron into wbank, unstalled.
    - Neuron boundary: the iact engine has issued its last read and the next-bank load has completed. Then in the next cycle: rbank flips, wbank flips, neuron count advances, and the iact index restarts at 0.
    - If the weight load is not finished, the iact engine idles; a 0-cycle gap is required when fan_in>=2.
    - After the last neuron's final issue -> DRAIN.
  - DRAIN: wait 2 cycles for the pipe to empty; pulse done; busy=0 -> IDLE.
- Stall and start rules:
  - pe_ready low does not stop in-flight iacts; up to 2 still emerge. The PE must absorb them.
  - start while busy is ignored.
- Boundary cases:
  - fan_in=1: weight load and iact issue each take 1 cycle. Boundary rule still applies, giving 1 bubble per neuron.
  - num_neurons=1: no overlapped load; RUN goes straight to DRAIN.
  - fan_in=2**AW: the index counter is AW+1 wide, so there is no wrap aliasing.
  - Async rst mid-operation: pipe cleared; valids drop immediately; no done pulse.
- Flag alignment:
  - neuron_last and read_bank are registered alongside iact.
  - weight_bank is registered alongside weight.
  - Never: weight_valid with weight_bank == read_bank while iact_valid for the same neuron.

Decomposition:
- Shared package: FSM state encoding (IDLE, FILL, RUN, DRAIN); MEM_LAT=1 and OUT_LAT=2 constants.
- One sub-module, feed_pipe: a 2-stage valid/data/tag delay line, instantiated once for the weight path and once for the iact path.

Test Plan:
- fan_in=4, num_neurons=1, pe_ready=1 -> wmem_addr 0..3; 4 weight_valid to bank 0; iacts idx 0..3 with read_bank=0; neuron_last on idx 3; done 2 cycles after last issue.
- fan_in=4, num_neurons=3 -> bank-1 load (addr 4..7) overlaps neuron-0 iacts; neuron 2 weights addr 8..11 into bank 0; no iact gap between neurons; 3 neuron_last pulses.
- pe_ready low for 3 cycles mid-neuron -> at most 2 iacts emerge during the stall; resume at the correct idx; weight load completes unaffected.
- fan_in=1, num_neurons=4 -> each neuron has exactly 1 iact with neuron_last; banks alternate 0,1,0,1; done once.
- fan_in=256 -> amem_addr 0..255 with no wrap; wmem_addr base for neuron 1 = 256.
- rst low during RUN -> all outputs 0 asynchronously; start after release begins cleanly at addr 0.
